mux_nx1_stream: RTL

- Parametrised N-to-1 multiplexer for valid/ready data streams, with a registered output stage.
- Channel choice is either an external select (MODE=0) or internal round-robin arbitration among valid channels (MODE=1).
- Sits wherever several producers share one consumer. Supersedes fixed-width combinational 2:1/4:1 mux trees.

---
 rtl/mux_nx1_stream_if.sv | 46 ++++
 rtl/mux_nx1_stream.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mux_nx1_stream_if.sv
// -----------------------------------------------------------------------------
// mux_nx1_stream_if
// Bundles the stream signals of the N-to-1 stream multiplexer.
//
// Signals:
//   i_data  [N_CH*DATA_W] channel k data at [k*DATA_W +: DATA_W]
//   i_valid [N_CH]        per-channel valid
//   i_last  [N_CH]        per-channel end-of-packet marker
//   i_ready [N_CH]        per-channel ready (driven by the mux)
//   s       [SEL_W]       external channel select (MODE=0 only)
//   y_data  [DATA_W]      registered output data
//   y_valid               output valid
//   y_last                registered last of the transferred beat
//   y_ch    [SEL_W]       channel index of the current output beat
//   y_ready               downstream ready
//
// Modports:
//   master : the surrounding producers/consumer (drive inputs, see outputs)
//   slave  : the multiplexer itself
// -----------------------------------------------------------------------------
interface mux_nx1_stream_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(N_CH)
);
  logic [N_CH*DATA_W-1:0] i_data;
  logic [N_CH-1:0]        i_valid;
  logic [N_CH-1:0]        i_last;
  logic [N_CH-1:0]        i_ready;
  logic [SEL_W-1:0]       s;
  logic [DATA_W-1:0]      y_data;
  logic                   y_valid;
  logic                   y_last;
  logic [SEL_W-1:0]       y_ch;
  logic                   y_ready;

  modport master (
    output i_data, i_valid, i_last, s, y_ready,
    input  i_ready, y_data, y_valid, y_last, y_ch
  );

  modport slave (
    input  i_data, i_valid, i_last, s, y_ready,
    output i_ready, y_data, y_valid, y_last, y_ch
  );
endinterface

// File: rtl/mux_nx1_stream.sv
// -----------------------------------------------------------------------------
// mux_nx1_stream
// N-to-1 multiplexer for valid/ready streams with a registered output stage.
// The channel is chosen either by the external select bus.s (MODE=0) or by
// round-robin arbitration among valid channels (MODE=1).
//
// Ports:
//   clk    in   clock, all state updates on the rising edge
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of mux_nx1_stream_if (i_data/i_valid/i_last/i_ready,
//               s, y_data/y_valid/y_last/y_ch/y_ready)
//
// Optional feature macro: MUX_STREAM_PKT_LOCK_EN
//   When defined and MODE=1, a packet lock keeps the grant on the channel
//   that started a packet (transfer with i_last=0) until its i_last=1 beat.
//   With MODE=0 the lock is inert. When undefined, arbitration is per beat.
// -----------------------------------------------------------------------------
module mux_nx1_stream #(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 8,
  parameter  int MODE   = 0,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_nx1_stream_if.slave    bus
);

  // Output register and round-robin pointer.
  logic              y_valid_reg;
  logic [DATA_W-1:0] y_data_reg;
  logic              y_last_reg;
  logic [SEL_W-1:0]  y_ch_reg;
  logic [SEL_W-1:0]  ptr_reg;

  logic              load;
  logic              locked;
  logic [SEL_W-1:0]  grant;
  logic              grant_valid;
  logic              xfer;
  logic [N_CH-1:0]   ready_vec;

  logic [DATA_W-1:0] ch_data [N_CH];

  // Slice the flat data bus into one word per channel.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign ch_data[gi] = bus.i_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Channel index reached by stepping d positions past p, wrapping at N_CH.
  function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] p,
                                               input int d);
    return SEL_W'((int'(p) + d) % N_CH);
  endfunction

  // The register can take a new beat when empty or being drained this cycle.
  assign load = !y_valid_reg || bus.y_ready;

`ifdef MUX_STREAM_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_t;
  lock_state_t lock_state_reg;

  assign locked = (MODE == 1) && (lock_state_reg == LOCKED);

  // Packet lock: a beat without last opens a packet, a beat with last
  // closes it. Only meaningful with round-robin arbitration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_state_reg <= IDLE;
    end else if ((MODE == 1) && xfer) begin
      lock_state_reg <= bus.i_last[grant] ? IDLE : LOCKED;
    end
  end
`else
  assign locked = 1'b0;
`endif

  // Grant selection. A grant is only issued to a channel that is presenting
  // a beat, so i_ready never advertises to a producer with nothing to send.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (MODE == 0) begin
      if (int'(bus.s) < N_CH) begin
        grant       = bus.s;
        grant_valid = bus.i_valid[bus.s];
      end
    end else if (locked) begin
      // Mid-packet: stay on the owning channel, never interleave.
      grant       = ptr_reg;
      grant_valid = bus.i_valid[ptr_reg];
    end else begin
      // Scan from the farthest offset down so the nearest valid channel
      // after ptr is the last one written and therefore wins.
      for (int d = N_CH; d >= 1; d--) begin
        if (bus.i_valid[rr_idx(ptr_reg, d)]) begin
          grant       = rr_idx(ptr_reg, d);
          grant_valid = 1'b1;
        end
      end
    end
  end

  assign xfer = rst_n && load && grant_valid;

  always_comb begin
    ready_vec = '0;
    if (xfer) begin
      ready_vec[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_valid_reg <= 1'b0;
      y_data_reg  <= '0;
      y_last_reg  <= 1'b0;
      y_ch_reg    <= '0;
      ptr_reg     <= SEL_W'(N_CH - 1);
    end else if (xfer) begin
      y_valid_reg <= 1'b1;
      y_data_reg  <= ch_data[grant];
      y_last_reg  <= bus.i_last[grant];
      y_ch_reg    <= grant;
      if (MODE == 1) begin
        ptr_reg <= grant;
      end
    end else if (bus.y_ready) begin
      // Drained with nothing to replace it; payload fields keep last value.
      y_valid_reg <= 1'b0;
    end
  end

  assign bus.i_ready = ready_vec;
  assign bus.y_valid = y_valid_reg;
  assign bus.y_data  = y_data_reg;
  assign bus.y_last  = y_last_reg;
  assign bus.y_ch    = y_ch_reg;

endmodule
